// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Memory side of the core's load/store port. Holds a synchronous
//             word-organised RAM. Decodes RV32I byte/half/word loads and
//             stores, signed and unsigned, with little-endian byte lanes.
//             Each request is answered with a one-cycle mem_ready pulse.
//             Rejected requests also raise mem_error and do not touch RAM.
//  Ports    : CLK             clock, rising edge
//             RST             synchronous reset, active-high
//             address_DMEM    byte address of the request
//             write_data_DMEM store data, right-aligned
//             MemRead         load request, held until mem_ready
//             MemWrite        store request, held until mem_ready
//             funct3          000 B, 001 H, 010 W, 100 BU, 101 HU
//             data_DMEM       registered load result, sign/zero-extended
//             mem_ready       one-cycle completion pulse
//             mem_error       high with mem_ready for a rejected request
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
   parameter int ADDR_W      = 10,
   parameter int DEPTH_WORDS = 256
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [ADDR_W-1:0] address_DMEM,
   input  logic [31:0]       write_data_DMEM,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [2:0]        funct3,
   output logic [31:0]       data_DMEM,
   output logic              mem_ready,
   output logic              mem_error
);

   localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      ACK  = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   logic [31:0] ram [DEPTH_WORDS];
   logic [31:0] rd_word;
   logic [1:0]  addr_lo;
   logic [2:0]  f3_q;
   logic        err_q;

   logic             req;
   logic             accept;
   logic             size_bad;
   logic             out_of_range;
   logic             misaligned;
   logic             req_error;
   logic             do_write;
   logic             do_read;
   logic [31:0]      addr_ext;
   logic [IDX_W-1:0] word_idx;
   logic [3:0]       lane_en;
   logic [31:0]      lane_data;
   logic [7:0]       byte_sel;
   logic [15:0]      half_sel;
   logic [31:0]      load_ext;

   assign req      = MemRead | MemWrite;
   assign accept   = (state == IDLE) && req;
   assign addr_ext = 32'(address_DMEM);
   // Upper address bits are zero whenever the range check passes, so only
   // the bits that select a word inside the array are used as the index.
   assign word_idx = address_DMEM[IDX_W+1:2];

   // Request screening: every condition is evaluated and any hit rejects.
   always_comb begin
      size_bad = 1'b0;
      case (funct3)
         3'b000, 3'b001, 3'b010: size_bad = 1'b0;
         3'b100, 3'b101:         size_bad = MemWrite;  // unsigned forms are load-only
         default:                size_bad = 1'b1;
      endcase
      out_of_range = (addr_ext >= LIMIT);
      misaligned   = ((funct3[1:0] == 2'b01) && address_DMEM[0]) ||
                     ((funct3 == 3'b010) && (address_DMEM[1:0] != 2'b00));
      req_error    = (MemRead & MemWrite) | size_bad | out_of_range | misaligned;
   end

   // Reset wins over a request arriving on the same edge.
   assign do_write = accept && !req_error && MemWrite && !RST;
   assign do_read  = accept && !req_error && MemRead  && !RST;

   // Store data is replicated across lanes so the enables alone pick the target.
   always_comb begin
      lane_en   = 4'hF;
      lane_data = write_data_DMEM;
      case (funct3[1:0])
         2'b00: begin
            lane_en   = 4'b0001 << address_DMEM[1:0];
            lane_data = {4{write_data_DMEM[7:0]}};
         end
         2'b01: begin
            lane_en   = address_DMEM[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{write_data_DMEM[15:0]}};
         end
         default: begin
            lane_en   = 4'hF;
            lane_data = write_data_DMEM;
         end
      endcase
   end

   // RAM array without reset so that contents survive RST.
   always_ff @(posedge CLK) begin
      if (do_write) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
               ram[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
         end
      end
      if (do_read) begin
         rd_word <= ram[word_idx];
      end
   end

   // Lane select and extension of the word fetched during acceptance.
   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = rd_word[7:0];
         2'd1:    byte_sel = rd_word[15:8];
         2'd2:    byte_sel = rd_word[23:16];
         default: byte_sel = rd_word[31:24];
      endcase
      half_sel = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
      case (f3_q)
         3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_ext = {24'h0, byte_sel};
         3'b101:  load_ext = {16'h0, half_sel};
         default: load_ext = rd_word;
      endcase
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Request context and load result. Write data is consumed at the
   // acceptance edge itself, so it needs no holding register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         data_DMEM <= 32'h0;
         addr_lo   <= 2'b00;
         f3_q      <= 3'b000;
         err_q     <= 1'b0;
      end else begin
         if (accept) begin
            addr_lo <= address_DMEM[1:0];
            f3_q    <= funct3;
            err_q   <= req_error;
         end
         if (state == RD) begin
            data_DMEM <= load_ext;
         end
      end
   end

   // Next state and completion outputs.
   always_comb begin
      state_next = state;
      mem_ready  = 1'b0;
      mem_error  = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (req_error || MemWrite) begin
                  state_next = ACK;
               end else begin
                  state_next = RD;
               end
            end
         end
         RD: begin
            state_next = RESP;
         end
         ACK: begin
            mem_ready  = 1'b1;
            mem_error  = err_q;
            state_next = IDLE;
         end
         RESP: begin
            mem_ready  = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Directed self-checking bench for dmem_responder. A reference
//             RAM model produces the expected response of every request,
//             which is queued at issue time and compared when mem_ready
//             appears.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

   localparam int ADDR_W      = 10;
   localparam int DEPTH_WORDS = 128;

   logic              CLK;
   logic              RST;
   logic [ADDR_W-1:0] address_DMEM;
   logic [31:0]       write_data_DMEM;
   logic              MemRead;
   logic              MemWrite;
   logic [2:0]        funct3;
   logic [31:0]       data_DMEM;
   logic              mem_ready;
   logic              mem_error;

   dmem_responder #(
      .ADDR_W      (ADDR_W),
      .DEPTH_WORDS (DEPTH_WORDS)
   ) dut (
      .CLK             (CLK),
      .RST             (RST),
      .address_DMEM    (address_DMEM),
      .write_data_DMEM (write_data_DMEM),
      .MemRead         (MemRead),
      .MemWrite        (MemWrite),
      .funct3          (funct3),
      .data_DMEM       (data_DMEM),
      .mem_ready       (mem_ready),
      .mem_error       (mem_error)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ref_mem [DEPTH_WORDS];
   logic [31:0] ref_data;
   int          total;
   int          bad;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic model_err(input logic rd, input logic wr,
                                      input logic [2:0] f3, input logic [9:0] addr);
      logic e;
      e = rd && wr;
      if (!(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
            (rd && !wr && (f3 == 3'b100 || f3 == 3'b101)))) e = 1'b1;
      if (int'(addr) >= DEPTH_WORDS * 4) e = 1'b1;
      if ((f3 == 3'b001 || f3 == 3'b101) && addr[0]) e = 1'b1;
      if (f3 == 3'b010 && addr[1:0] != 2'b00) e = 1'b1;
      return e;
   endfunction

   task automatic model_store(input logic [2:0] f3, input logic [9:0] addr, input logic [31:0] wd);
      int w;
      int b;
      w = int'(addr[9:2]);
      b = int'(addr[1:0]);
      case (f3)
         3'b000:  ref_mem[w][8*b +: 8] = wd[7:0];
         3'b001:  ref_mem[w][8*b +: 16] = wd[15:0];
         default: ref_mem[w] = wd;
      endcase
   endtask

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [9:0] addr);
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] h;
      w = ref_mem[int'(addr[9:2])];
      b = 8'(w >> (8 * int'(addr[1:0])));
      h = 16'(w >> (8 * int'(addr[1:0])));
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'h0, b};
         3'b101:  return {16'h0, h};
         default: return w;
      endcase
   endfunction

   // Issue one request at a negedge with the DUT idle; returns at a
   // negedge with the DUT idle again.
   task automatic req(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [9:0] addr, input logic [31:0] wd, input string tag);
      exp_t e;
      exp_t got;
      int   lat;
      logic seen;
      e.err = model_err(rd, wr, f3, addr);
      e.lat = (!e.err && rd) ? 2 : 1;
      if (!e.err && wr) model_store(f3, addr, wd);
      if (!e.err && rd) ref_data = model_load(f3, addr);
      e.data = ref_data;
      sb.push_back(e);

      address_DMEM    = addr;
      write_data_DMEM = wd;
      funct3          = f3;
      MemRead         = rd;
      MemWrite        = wr;
      seen = 1'b0;
      lat  = 0;
      while (!seen && lat < 8) begin
         @(negedge CLK);
         lat++;
         if (mem_ready) seen = 1'b1;
      end
      got = sb.pop_front();
      check({tag, "_ready_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         check({tag, "_latency"}, 32'(lat), 32'(got.lat));
         check({tag, "_error"}, 32'(mem_error), 32'(got.err));
         check({tag, "_data"}, data_DMEM, got.data);
      end
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      @(negedge CLK);
      check({tag, "_ready_drop"}, 32'(mem_ready), 32'd0);
   endtask

   initial begin
      total           = 0;
      bad             = 0;
      ref_data        = 32'h0;
      RST             = 1'b1;
      MemRead         = 1'b0;
      MemWrite        = 1'b0;
      funct3          = 3'b000;
      address_DMEM    = '0;
      write_data_DMEM = 32'h0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      check("reset_ready", 32'(mem_ready), 32'd0);
      check("reset_error", 32'(mem_error), 32'd0);
      check("reset_data", data_DMEM, 32'h0);

      // Word store and load, then sub-word loads of the same word.
      req(1'b0, 1'b1, 3'b010, 10'h010, 32'hDEADBEEF, "sw_010");
      req(1'b1, 1'b0, 3'b010, 10'h010, 32'h0, "lw_010");
      check("lw_010_value", data_DMEM, 32'hDEADBEEF);
      req(1'b1, 1'b0, 3'b000, 10'h013, 32'h0, "lb_013");
      check("lb_013_value", data_DMEM, 32'hFFFFFFDE);
      req(1'b1, 1'b0, 3'b100, 10'h013, 32'h0, "lbu_013");
      check("lbu_013_value", data_DMEM, 32'h000000DE);
      req(1'b1, 1'b0, 3'b001, 10'h010, 32'h0, "lh_010");
      check("lh_010_value", data_DMEM, 32'hFFFFBEEF);
      req(1'b1, 1'b0, 3'b101, 10'h012, 32'h0, "lhu_012");
      check("lhu_012_value", data_DMEM, 32'h0000DEAD);

      // Partial stores leave the other lanes intact.
      req(1'b0, 1'b1, 3'b000, 10'h011, 32'h000000AA, "sb_011");
      req(1'b1, 1'b0, 3'b010, 10'h010, 32'h0, "lw_after_sb");
      check("lw_after_sb_value", data_DMEM, 32'hDEADAAEF);
      req(1'b0, 1'b1, 3'b001, 10'h012, 32'h00001234, "sh_012");
      req(1'b1, 1'b0, 3'b010, 10'h010, 32'h0, "lw_after_sh");
      check("lw_after_sh_value", data_DMEM, 32'h1234AAEF);
      req(1'b1, 1'b0, 3'b001, 10'h012, 32'h0, "lh_012_pos");
      check("lh_012_value", data_DMEM, 32'h00001234);

      // Rejected requests: no RAM change, data_DMEM holds.
      req(1'b1, 1'b0, 3'b010, 10'h012, 32'h0, "err_lw_mis");
      req(1'b0, 1'b1, 3'b001, 10'h011, 32'hFFFFFFFF, "err_sh_mis");
      req(1'b0, 1'b1, 3'b100, 10'h010, 32'hFFFFFFFF, "err_st_f3");
      req(1'b1, 1'b1, 3'b010, 10'h010, 32'hFFFFFFFF, "err_rdwr");
      check("err_data_hold", data_DMEM, 32'h00001234);
      req(1'b1, 1'b0, 3'b010, 10'h010, 32'h0, "lw_after_err");
      check("lw_after_err_value", data_DMEM, 32'h1234AAEF);

      // Range boundary.
      req(1'b1, 1'b0, 3'b010, 10'h200, 32'h0, "err_range");
      req(1'b0, 1'b1, 3'b010, 10'h1FC, 32'h55AA55AA, "sw_top");
      req(1'b1, 1'b0, 3'b010, 10'h1FC, 32'h0, "lw_top");
      check("lw_top_value", data_DMEM, 32'h55AA55AA);

      // Reset while a load sits in RD: no completion, data cleared.
      address_DMEM = 10'h010;
      funct3       = 3'b010;
      MemRead      = 1'b1;
      @(negedge CLK);
      check("rst_rd_no_ready", 32'(mem_ready), 32'd0);
      RST = 1'b1;
      @(negedge CLK);
      RST      = 1'b0;
      MemRead  = 1'b0;
      ref_data = 32'h0;
      check("rst_rd_ready", 32'(mem_ready), 32'd0);
      check("rst_rd_data", data_DMEM, 32'h0);
      @(negedge CLK);
      check("rst_rd_ready_later", 32'(mem_ready), 32'd0);

      // Reset during ACK of a store: the write persists.
      model_store(3'b010, 10'h020, 32'h11111111);
      address_DMEM    = 10'h020;
      write_data_DMEM = 32'h11111111;
      funct3          = 3'b010;
      MemWrite        = 1'b1;
      @(negedge CLK);
      check("rst_ack_ready", 32'(mem_ready), 32'd1);
      RST      = 1'b1;
      MemWrite = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      check("rst_ack_after_ready", 32'(mem_ready), 32'd0);
      @(negedge CLK);
      req(1'b1, 1'b0, 3'b010, 10'h020, 32'h0, "lw_020");
      check("lw_020_value", data_DMEM, 32'h11111111);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
